fwrisc_fetch: RTL and testbench

Instruction-fetch stage. It sits directly upstream of the decode stage.
- Reads 32-bit words from the instruction bus.
- Extracts 16-bit (compressed) and 32-bit instructions from halfword-aligned PCs, including 32-bit instructions that span two words.
- Presents the instruction to decode with a valid/complete handshake.
- Holds one buffered word so that consecutive instructions in the same word need no bus access.

---
 rtl/fwrisc_fetch.sv | 128 ++++++++++++
 tb/tb_fwrisc_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_fetch.sv
// Instruction-fetch stage: reads 32-bit bus words and hands 16/32-bit instructions to decode.
// Keeps the last fetched word so that instructions already inside it are served without a bus access.
`timescale 1ns/1ps
module fwrisc_fetch #(
  parameter bit          ENABLE_COMPRESSED = 1'b1,
  parameter logic [31:0] RESET_VECTOR      = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] ibus_adr,
  output logic        ibus_req,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic        fetch_valid,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] pc,
  input  logic        decode_complete,
  input  logic [31:0] next_pc
);

  typedef enum logic [1:0] {FETCH0, FETCH1, VALID, HIT} state_t;

  state_t      state;
  logic [31:0] buf_word;
  logic [29:0] buf_adr;
  logic        buf_vld;
  logic [15:0] lo_half;

  logic        pc_hi;
  logic [15:0] rd_half;
  logic [15:0] buf_half;
  logic [31:0] npc;
  logic        npc_hit;
  logic        unused_bits;

  function automatic logic is_c(input logic [15:0] h);
    return ENABLE_COMPRESSED && (h[1:0] != 2'b11);
  endfunction

  assign pc_hi       = ENABLE_COMPRESSED ? pc[1] : 1'b0;
  assign rd_half     = pc_hi ? ibus_rdata[31:16] : ibus_rdata[15:0];
  assign buf_half    = pc_hi ? buf_word[31:16] : buf_word[15:0];
  assign npc         = {next_pc[31:2], (ENABLE_COMPRESSED ? next_pc[1] : 1'b0), 1'b0};
  assign unused_bits = next_pc[0];

  // A hit needs the whole instruction in the buffer: any low-half start, or a compressed high half.
  assign npc_hit = buf_vld && (npc[31:2] == buf_adr) && (!npc[1] || is_c(buf_word[31:16]));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FETCH0;
      ibus_req    <= 1'b0;
      ibus_adr    <= 32'h0;
      fetch_valid <= 1'b0;
      instr       <= 32'h0;
      instr_c     <= 1'b0;
      pc          <= RESET_VECTOR;
      buf_word    <= 32'h0;
      buf_adr     <= 30'h0;
      buf_vld     <= 1'b0;
      lo_half     <= 16'h0;
    end else begin
      case (state)
        FETCH0: begin
          if (!ibus_req) begin
            ibus_req <= 1'b1;
            ibus_adr <= {pc[31:2], 2'b00};
          end else if (ibus_ack) begin
            ibus_req <= 1'b0;
            buf_word <= ibus_rdata;
            buf_adr  <= pc[31:2];
            buf_vld  <= 1'b1;
            if (is_c(rd_half)) begin
              instr       <= {16'h0, rd_half};
              instr_c     <= 1'b1;
              fetch_valid <= 1'b1;
              state       <= VALID;
            end else if (!pc_hi) begin
              instr       <= ibus_rdata;
              instr_c     <= 1'b0;
              fetch_valid <= 1'b1;
              state       <= VALID;
            end else begin
              lo_half <= ibus_rdata[31:16];
              state   <= FETCH1;
            end
          end
        end
        FETCH1: begin
          // Second word of a spanning instruction; word index wraps at 2^30.
          if (!ibus_req) begin
            ibus_req <= 1'b1;
            ibus_adr <= {pc[31:2] + 30'd1, 2'b00};
          end else if (ibus_ack) begin
            ibus_req    <= 1'b0;
            instr       <= {ibus_rdata[15:0], lo_half};
            instr_c     <= 1'b0;
            buf_word    <= ibus_rdata;
            buf_adr     <= pc[31:2] + 30'd1;
            fetch_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (decode_complete) begin
            fetch_valid <= 1'b0;
            pc          <= npc;
            state       <= npc_hit ? HIT : FETCH0;
          end
        end
        HIT: begin
          if (is_c(buf_half)) begin
            instr   <= {16'h0, buf_half};
            instr_c <= 1'b1;
          end else begin
            instr   <= buf_word;
            instr_c <= 1'b0;
          end
          fetch_valid <= 1'b1;
          state       <= VALID;
        end
        default: state <= FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Bench for fwrisc_fetch: random bus latency and next_pc choices against a halfword-level memory model.
// A second instance with compressed support disabled covers word-aligned behaviour.
`timescale 1ns/1ps
module tb_fwrisc_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ibus_adr;
  logic        ibus_req;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        fetch_valid;
  logic [31:0] instr;
  logic        instr_c;
  logic [31:0] pc;
  logic        decode_complete;
  logic [31:0] next_pc;

  logic        nc_reset;
  logic [31:0] nc_adr;
  logic        nc_req;
  logic        nc_ack;
  logic [31:0] nc_rdata;
  logic        nc_valid;
  logic [31:0] nc_instr;
  logic        nc_instr_c;
  logic [31:0] nc_pc;
  logic        nc_dc;
  logic [31:0] nc_npc;

  always #5 clock = ~clock;

  fwrisc_fetch #(.ENABLE_COMPRESSED(1'b1), .RESET_VECTOR(32'h8000_0000)) u_dut (
    .clock(clock), .reset(reset), .ibus_adr(ibus_adr), .ibus_req(ibus_req),
    .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata), .fetch_valid(fetch_valid),
    .instr(instr), .instr_c(instr_c), .pc(pc),
    .decode_complete(decode_complete), .next_pc(next_pc));

  fwrisc_fetch #(.ENABLE_COMPRESSED(1'b0), .RESET_VECTOR(32'h0000_0000)) u_nc (
    .clock(clock), .reset(nc_reset), .ibus_adr(nc_adr), .ibus_req(nc_req),
    .ibus_ack(nc_ack), .ibus_rdata(nc_rdata), .fetch_valid(nc_valid),
    .instr(nc_instr), .instr_c(nc_instr_c), .pc(nc_pc),
    .decode_complete(nc_dc), .next_pc(nc_npc));

  typedef struct {
    logic [31:0] instr;
    logic        c;
    logic [31:0] pc;
    int          reads;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [bit [29:0]];
  int          n_pass = 0;
  int          n_total = 0;
  int          reads_seen = 0;
  int          nc_acks = 0;
  bit          resp_en = 1'b0;
  bit          buf_v = 1'b0;
  logic [29:0] buf_w = 30'h0;
  logic [31:0] cur_pc = 32'h0;
  int          cur_len = 4;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    logic [15:0] a, b;
    if (!mem.exists(w)) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) b[1:0] = 2'b11;
      mem[w] = {b, a};
    end
    return mem[w];
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a[31:2]);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Expected instruction and number of bus reads, from the fetch rules over a halfword memory.
  function automatic void model_push(input logic [31:0] npc);
    logic [31:0] p;
    logic [15:0] h0;
    exp_t        e;
    p  = {npc[31:1], 1'b0};
    h0 = hw(p);
    e.pc = p;
    e.c  = (h0[1:0] != 2'b11);
    e.instr = e.c ? {16'h0, h0} : {hw(p + 32'd2), h0};
    if (buf_v && p[31:2] == buf_w && (!p[1] || e.c)) begin
      e.reads = 0;
    end else if (p[1] && !e.c) begin
      e.reads = 2;
      buf_w = p[31:2] + 30'd1;
      buf_v = 1'b1;
    end else begin
      e.reads = 1;
      buf_w = p[31:2];
      buf_v = 1'b1;
    end
    q.push_back(e);
    cur_pc  = p;
    cur_len = e.c ? 2 : 4;
  endfunction

  // Bus slave for the main instance: random ack latency.
  initial begin
    ibus_ack = 1'b0;
    ibus_rdata = 32'h0;
    forever begin
      @(negedge clock);
      if (resp_en) begin
        if (ibus_req && $urandom_range(0, 2) != 0) begin
          ibus_ack   = 1'b1;
          ibus_rdata = mem_rd(ibus_adr[31:2]);
          reads_seen++;
        end else begin
          ibus_ack   = 1'b0;
          ibus_rdata = $urandom;
        end
      end
    end
  end

  // Bus slave for the word-aligned instance: immediate ack.
  initial begin
    nc_ack = 1'b0;
    nc_rdata = 32'h0;
    forever begin
      @(negedge clock);
      nc_ack = nc_req;
      nc_rdata = (nc_adr == 32'h0) ? 32'h0000_0001 :
                 (nc_adr == 32'h4) ? 32'h0010_0093 : 32'hFFFF_FFFF;
      if (nc_req) nc_acks++;
    end
  end

  // Monitor: compares each new presentation and checks hold/drop behaviour of fetch_valid.
  initial begin
    bit          prev_v;
    bit          dc_s;
    bit          rst_s;
    logic [63:0] snap;
    exp_t        e;
    prev_v = 1'b0;
    snap   = 64'h0;
    forever begin
      @(posedge clock);
      dc_s  = decode_complete;
      rst_s = reset;
      #1;
      if (rst_s) begin
        if (prev_v && !dc_s) begin
          check("valid_held", {63'h0, fetch_valid}, 64'h1);
          if (fetch_valid) check("outputs_stable", {instr, pc}, snap);
        end
        if (!prev_v && fetch_valid) begin
          if (q.size() == 0) begin
            check("unexpected_presentation", {32'h0, pc}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("instr", {32'h0, instr}, {32'h0, e.instr});
            check("instr_c", {63'h0, instr_c}, {63'h0, e.c});
            check("pc", {32'h0, pc}, {32'h0, e.pc});
            check("bus_reads", 64'(reads_seen), 64'(e.reads));
          end
          reads_seen = 0;
        end
      end
      prev_v = fetch_valid;
      snap   = {instr, pc};
    end
  end

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (fetch_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
    check("fetch_valid_timeout", 64'h0, 64'h1);
  endtask

  initial begin
    logic [31:0] dir_pc [5];
    logic [31:0] npc;
    bit          ok;
    int          r;
    reset = 1'b0;
    nc_reset = 1'b0;
    decode_complete = 1'b0;
    next_pc = 32'h0;
    nc_dc = 1'b0;
    nc_npc = 32'h0;
    dir_pc[0] = 32'h0000_0100;
    dir_pc[1] = 32'h0000_0102;
    dir_pc[2] = 32'h0000_0202;
    dir_pc[3] = 32'h0000_0400;
    dir_pc[4] = 32'hFFFF_FFFE;
    mem[30'h2000_0000] = 32'h0000_0013;
    mem[30'h0000_0040] = 32'h0001_4505;
    mem[30'h0000_0080] = 32'h0513_ABCD;
    mem[30'h0000_0081] = 32'h1234_0000;
    mem[30'h3FFF_FFFF] = 32'h0003_5678;
    mem[30'h0000_0000] = 32'hAAAA_1234;

    // Word-aligned instance
    repeat (3) @(negedge clock);
    nc_reset = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = nc_valid;
    end
    check("nc_first_valid", {63'h0, ok}, 64'h1);
    check("nc_instr0", {32'h0, nc_instr}, 64'h0000_0001);
    check("nc_instr_c0", {63'h0, nc_instr_c}, 64'h0);
    check("nc_pc0", {32'h0, nc_pc}, 64'h0);
    nc_dc = 1'b1;
    nc_npc = 32'h6;
    @(negedge clock);
    nc_dc = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = nc_valid;
    end
    check("nc_second_valid", {63'h0, ok}, 64'h1);
    check("nc_pc1", {32'h0, nc_pc}, 64'h4);
    check("nc_instr1", {32'h0, nc_instr}, 64'h0010_0093);
    check("nc_instr_c1", {63'h0, nc_instr_c}, 64'h0);
    check("nc_bus_reads", 64'(nc_acks), 64'd2);

    // Main instance: reset values
    @(negedge clock);
    check("rst_req", {63'h0, ibus_req}, 64'h0);
    check("rst_adr", {32'h0, ibus_adr}, 64'h0);
    check("rst_valid", {63'h0, fetch_valid}, 64'h0);
    check("rst_instr", {32'h0, instr}, 64'h0);
    check("rst_instr_c", {63'h0, instr_c}, 64'h0);
    check("rst_pc", {32'h0, pc}, 64'h8000_0000);

    model_push(32'h8000_0000);
    resp_en = 1'b1;
    reset = 1'b1;
    wait_valid(ok);
    repeat (5) @(negedge clock);

    for (int n = 0; n < 260 && ok; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      if (n < 5) begin
        npc = dir_pc[n];
      end else begin
        r = $urandom_range(0, 9);
        if (r < 6) npc = cur_pc + 32'(cur_len);
        else if (r < 8) npc = 32'h1000 + 32'($urandom_range(0, 255)) * 2;
        else npc = cur_pc - 32'd4 + 32'($urandom_range(0, 4)) * 2;
        npc[0] = 1'($urandom_range(0, 1));
      end
      decode_complete = 1'b1;
      next_pc = npc;
      model_push(npc);
      @(negedge clock);
      if ($urandom_range(0, 3) == 0) begin
        decode_complete = 1'b1;
        next_pc = $urandom;
      end else begin
        decode_complete = 1'b0;
      end
      @(negedge clock);
      decode_complete = 1'b0;
      wait_valid(ok);
    end

    // Reset while a bus request is outstanding; a late ack must be ignored.
    @(negedge clock);
    resp_en = 1'b0;
    @(negedge clock);
    ibus_ack = 1'b0;
    decode_complete = 1'b1;
    next_pc = 32'h0000_3000;
    @(negedge clock);
    decode_complete = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clock);
      ok = ibus_req;
    end
    check("req_before_reset", {63'h0, ok}, 64'h1);
    reset = 1'b0;
    @(negedge clock);
    check("req_after_reset", {63'h0, ibus_req}, 64'h0);
    check("valid_after_reset", {63'h0, fetch_valid}, 64'h0);
    check("pc_after_reset", {32'h0, pc}, 64'h8000_0000);
    q.delete();
    buf_v = 1'b0;
    reset = 1'b1;
    ibus_ack = 1'b1;
    ibus_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    ibus_ack = 1'b0;
    check("stale_ack_ignored", {63'h0, fetch_valid}, 64'h0);
    check("restart_req", {63'h0, ibus_req}, 64'h1);
    check("restart_adr", {32'h0, ibus_adr}, 64'h8000_0000);
    reads_seen = 0;
    model_push(32'h8000_0000);
    resp_en = 1'b1;
    wait_valid(ok);
    @(negedge clock);
    check("queue_drained", 64'(q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
